// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the pc, captures ROM words into a DEPTH-entry
// {pc, instr} queue and hands them to decode. Optional counters: FETCH_PERF_EN.
module fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter int          IMEM_WORDS = 400,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        fetch_done_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [15:0] perf_flush_o,
    output logic [31:0] perf_full_o
`endif
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   ent_pc_q    [DEPTH];
    logic [31:0]   ent_pc_d    [DEPTH];
    logic [31:0]   ent_instr_q [DEPTH];
    logic [31:0]   ent_instr_d [DEPTH];

    logic in_range;
    logic full;
    logic push;
    logic pop;

    assign in_range = (pc_q < IMEM_LIMIT);
    assign full     = (count_q == FULL_CNT);
    // Push looks only at the registered count, so a pop never frees a slot for the same edge.
    assign push     = !redirect_i && !full && in_range;
    assign pop      = !redirect_i && id_valid_o && id_ready_i;

    assign pc_o         = pc_q;
    assign fetch_done_o = !in_range;
    assign id_valid_o   = (count_q != '0);
    assign id_pc_o      = id_valid_o ? ent_pc_q[rd_ptr_q] : 32'd0;
    assign id_instr_o   = id_valid_o ? ent_instr_q[rd_ptr_q] : 32'd0;

    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        if (redirect_i) begin
            pc_d     = redirect_pc_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                ent_pc_d[wr_ptr_q]    = pc_q;
                ent_instr_d[wr_ptr_q] = instr_i;
                wr_ptr_d              = wr_ptr_q + 1'b1;
                pc_d                  = pc_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]    <= 32'd0;
                ent_instr_q[i] <= 32'd0;
            end
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ent_pc_q    <= ent_pc_d;
            ent_instr_q <= ent_instr_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_full_q, perf_full_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, push};
        perf_flush_d   = perf_flush_q + {15'd0, redirect_i};
        perf_full_d    = perf_full_q + {31'd0, (full && in_range)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'd0;
            perf_flush_q   <= 16'd0;
            perf_full_q    <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flush_q   <= perf_flush_d;
            perf_full_q    <= perf_full_d;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_flush_o   = perf_flush_q;
    assign perf_full_o    = perf_full_q;
`endif

endmodule
